// File: rtl/mem_dma_pkg.sv
// Shared types and constants for the mem_dma block-move engine.
package mem_dma_pkg;

  localparam int unsigned MEM_WIDTH = 12;

  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    READ0  = 3'd1,
    STREAM = 3'd2,
    LAST   = 3'd3,
    FIN    = 3'd4
  } state_t;

endpackage

// File: rtl/mem_dma_engine_if.sv
// Dual-port data-memory bus: port 1 reads (source), port 2 writes (destination).
interface mem_dma_engine_if
  import mem_dma_pkg::*;
#(
  parameter int unsigned mem_width = MEM_WIDTH
);

  logic [mem_width-1:0] ram_address1;
  logic                 ram_mem_write1;
  logic [mem_width-1:0] ram_datain1;
  logic [mem_width-1:0] ram_dataout1;
  logic [mem_width-1:0] ram_address2;
  logic                 ram_mem_write2;
  logic [mem_width-1:0] ram_datain2;

  modport master (
    output ram_address1, ram_mem_write1, ram_datain1,
    input  ram_dataout1,
    output ram_address2, ram_mem_write2, ram_datain2
  );

  modport slave (
    input  ram_address1, ram_mem_write1, ram_datain1,
    output ram_dataout1,
    input  ram_address2, ram_mem_write2, ram_datain2
  );

endinterface

// File: rtl/mem_dma_addr_gen.sv
// Loadable base-plus-offset address counter wrapping at mem_size, with a
// remaining-word count and a flag marking the final address of the run.
module mem_dma_addr_gen
  import mem_dma_pkg::*;
#(
  parameter int unsigned mem_width = MEM_WIDTH,
  parameter int unsigned mem_size  = 2 ** mem_width
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [mem_width-1:0] base,
  input  logic [mem_width-1:0] count,
  input  logic                 step,
  output logic [mem_width-1:0] addr,
  output logic                 last
);

  logic [mem_width-1:0] remaining;

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr      <= '0;
      remaining <= '0;
    end else if (load) begin
      addr      <= base;
      remaining <= count;
    end else if (step) begin
      addr      <= (addr == mem_width'(mem_size - 1)) ? '0 : addr + mem_width'(1);
      remaining <= remaining - mem_width'(1);
    end
  end

  assign last = (remaining == mem_width'(1));

endmodule

// File: rtl/mem_dma_engine.sv
// Block copy/fill engine driving both data-memory ports, one word per cycle.
// Optional MEM_DMA_CHECKSUM_EN adds a running sum of the words written.
module mem_dma_engine
  import mem_dma_pkg::*;
#(
  parameter int unsigned mem_width = MEM_WIDTH,
  parameter int unsigned mem_size  = 2 ** mem_width
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [mem_width-1:0] src_addr,
  input  logic [mem_width-1:0] dst_addr,
  input  logic [mem_width-1:0] length,
  input  logic [mem_width-1:0] fill_value,
  input  logic                 abort,
  output logic                 busy,
  output logic                 done,
  output logic                 aborted,
  output logic [mem_width-1:0] words_moved,
`ifdef MEM_DMA_CHECKSUM_EN
  output logic [mem_width-1:0] checksum,
`endif
  mem_dma_engine_if.master     ram
);

  state_t               state, state_n;
  logic                 mode_q;
  logic [mem_width-1:0] fill_q;
  logic                 we_q, we_n;
  logic                 accept, abort_hit, step_src;
  logic                 src_last, dst_last;
  logic [mem_width-1:0] src_cur, dst_cur;

  mem_dma_addr_gen #(
    .mem_width (mem_width),
    .mem_size  (mem_size)
  ) u_src (
    .clk   (clk),
    .reset (reset),
    .load  (accept && (mode == MODE_COPY)),
    .base  (src_addr),
    .count (length),
    .step  (step_src),
    .addr  (src_cur),
    .last  (src_last)
  );

  mem_dma_addr_gen #(
    .mem_width (mem_width),
    .mem_size  (mem_size)
  ) u_dst (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .base  (dst_addr),
    .count (length),
    .step  (we_q),
    .addr  (dst_cur),
    .last  (dst_last)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      mode_q      <= MODE_COPY;
      fill_q      <= '0;
      aborted     <= 1'b0;
      words_moved <= '0;
`ifdef MEM_DMA_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      state <= state_n;
      we_q  <= we_n;
      if (accept) begin
        mode_q      <= mode;
        fill_q      <= fill_value;
        aborted     <= 1'b0;
        words_moved <= '0;
`ifdef MEM_DMA_CHECKSUM_EN
        checksum    <= '0;
`endif
      end else begin
        if (abort_hit) aborted <= 1'b1;
        if (we_q) begin
          words_moved <= words_moved + mem_width'(1);
`ifdef MEM_DMA_CHECKSUM_EN
          checksum    <= checksum + ram.ram_datain2;
`endif
        end
      end
    end
  end

  // A zero-length request passes through LAST with no write so that busy
  // shows for one cycle and done lands two cycles after start.
  always_comb begin
    state_n   = state;
    we_n      = 1'b0;
    accept    = 1'b0;
    abort_hit = 1'b0;
    step_src  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (length == '0) begin
            state_n = LAST;
          end else if (mode == MODE_COPY) begin
            state_n = READ0;
          end else begin
            state_n = STREAM;
            we_n    = 1'b1;
          end
        end
      end
      READ0: begin
        if (abort) begin
          state_n   = FIN;
          abort_hit = 1'b1;
        end else begin
          we_n     = 1'b1;
          state_n  = src_last ? LAST : STREAM;
          step_src = !src_last;
        end
      end
      STREAM: begin
        if (abort) begin
          state_n   = FIN;
          abort_hit = 1'b1;
        end else if (mode_q == MODE_FILL) begin
          if (dst_last) begin
            state_n = FIN;
          end else begin
            we_n = 1'b1;
          end
        end else begin
          we_n = 1'b1;
          if (src_last) begin
            state_n = LAST;
          end else begin
            step_src = 1'b1;
          end
        end
      end
      LAST: begin
        state_n   = FIN;
        abort_hit = abort;
      end
      FIN:     state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state == READ0) || (state == STREAM) || (state == LAST);
  assign done = (state == FIN);

  assign ram.ram_address1   = src_cur;
  assign ram.ram_mem_write1 = 1'b0;
  assign ram.ram_datain1    = '0;
  assign ram.ram_address2   = dst_cur;
  assign ram.ram_mem_write2 = we_q;
  // Copy data flows straight from the registered read port into the write port.
  assign ram.ram_datain2    = !we_q ? '0 : ((mode_q == MODE_COPY) ? ram.ram_dataout1 : fill_q);

endmodule

// File: tb/tb_mem_dma_engine.sv
// Self-checking bench for mem_dma_engine against a sequential block-move model.
module tb_mem_dma_engine;
  import mem_dma_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, mode, abort;
  logic [11:0] src_addr, dst_addr, length, fill_value;
  logic        busy, done, aborted;
  logic [11:0] words_moved;
`ifdef MEM_DMA_CHECKSUM_EN
  logic [11:0] checksum;
`endif

  mem_dma_engine_if #(.mem_width(12)) ram_bus ();

  mem_dma_engine #(.mem_width(12), .mem_size(4096)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .mode        (mode),
    .src_addr    (src_addr),
    .dst_addr    (dst_addr),
    .length      (length),
    .fill_value  (fill_value),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .words_moved (words_moved),
`ifdef MEM_DMA_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .ram         (ram_bus)
  );

  always #5 clk = ~clk;

  // Dual-port RAM: registered read on port 1, write on port 2, write-then-read.
  logic [11:0] mem [0:4095];
  logic        poke_en = 1'b0;
  logic [11:0] poke_addr = '0, poke_data = '0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    if (ram_bus.ram_mem_write2) mem[ram_bus.ram_address2] <= ram_bus.ram_datain2;
    if (ram_bus.ram_mem_write2 && ram_bus.ram_address2 == ram_bus.ram_address1)
      ram_bus.ram_dataout1 <= ram_bus.ram_datain2;
    else
      ram_bus.ram_dataout1 <= mem[ram_bus.ram_address1];
  end

  logic [11:0] ref_mem [0:4095];
  int unsigned compared = 0;
  int unsigned mismatched = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [11:0] a, input logic [11:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    ref_mem[a] = d;
    @(posedge clk); #1;
    poke_en = 1'b0;
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < 4096; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  // One transfer: the model computes every expected write (sequential ascending
  // semantics), timing, counts and status, and the DUT is sampled each cycle.
  task automatic run_xfer(input logic m, input logic [11:0] s, input logic [11:0] d,
                          input logic [11:0] n, input logic [11:0] f,
                          input int abort_at, input int reset_at, input logic abort_with_start);
    logic [11:0] exp_addr [$];
    logic [11:0] exp_data [$];
    logic [11:0] a, ra, v, sum;
    int wexp, done_exp, first_wr, nw, nbusy, ndone, done_k;
    sum = '0; nw = 0; nbusy = 0; ndone = 0; done_k = 0;
    if (n == 0) begin
      wexp = 0; done_exp = 2;
    end else if (reset_at != 0) begin
      wexp = m ? reset_at - 1 : reset_at - 2; done_exp = 0;
    end else if (abort_at != 0) begin
      wexp = m ? abort_at - 1 : abort_at - 2; done_exp = abort_at;
    end else begin
      wexp = n; done_exp = m ? n + 1 : n + 2;
    end
    first_wr = m ? 1 : 2;
    for (int j = 0; j < wexp; j++) begin
      a  = d + 12'(j);
      ra = s + 12'(j);
      v  = m ? f : ref_mem[ra];
      ref_mem[a] = v;
      exp_addr.push_back(a);
      exp_data.push_back(v);
      sum = sum + v;
    end
    mode = m; src_addr = s; dst_addr = d; length = n; fill_value = f;
    abort = abort_with_start;
    start = 1'b1;
    for (int k = 1; k <= int'(n) + 12; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      abort = (abort_at != 0 && k == abort_at - 1);
      if (reset_at != 0 && k == reset_at) begin
        check("rst_busy", busy, 0);
        check("rst_we2", ram_bus.ram_mem_write2, 0);
        check("rst_words", words_moved, 0);
        check("rst_addr1", ram_bus.ram_address1, 0);
        reset = 1'b1;
      end else begin
        reset = !(reset_at != 0 && k == reset_at - 1);
      end
      if (busy) nbusy++;
      if (ram_bus.ram_mem_write2) begin
        if (nw < wexp) begin
          check("wr_addr", ram_bus.ram_address2, exp_addr[nw]);
          check("wr_data", ram_bus.ram_datain2, exp_data[nw]);
          check("wr_cycle", k, first_wr + nw);
        end
        nw++;
      end
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          done_k = k;
          check("aborted", aborted, (abort_at != 0) ? 1 : 0);
          check("words_moved", words_moved, wexp);
`ifdef MEM_DMA_CHECKSUM_EN
          check("checksum", checksum, sum);
`endif
        end
      end
      if (done_exp != 0 && k > done_exp) break;
    end
    check("write_count", nw, wexp);
    check("done_count", ndone, (done_exp != 0) ? 1 : 0);
    if (done_exp != 0) check("done_cycle", done_k, done_exp);
    check("busy_cycles", nbusy, (reset_at != 0) ? reset_at - 1 : done_exp - 1);
  endtask

  initial begin
    logic        m;
    logic [11:0] s, d, n;
    int          ab;
    reset = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0;
    src_addr = '0; dst_addr = '0; length = '0; fill_value = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_aborted", aborted, 0);
    check("reset_we2", ram_bus.ram_mem_write2, 0);
    check("reset_words", words_moved, 0);
    check("reset_addr1", ram_bus.ram_address1, 0);
    check("reset_addr2", ram_bus.ram_address2, 0);
    check("reset_din2", ram_bus.ram_datain2, 0);
    check("reset_we1", ram_bus.ram_mem_write1, 0);
    check("reset_din1", ram_bus.ram_datain1, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 4096; i++) poke(12'(i), 12'($urandom));

    // Basic copy of four words.
    run_xfer(MODE_COPY, 12'h010, 12'h100, 12'd4, 12'h000, 0, 0, 1'b0);
    for (int i = 0; i < 4; i++) check("copy_image", mem[12'h100 + i], mem[12'h010 + i]);
    // Fill across the top of memory.
    run_xfer(MODE_FILL, 12'h000, 12'hFFE, 12'd4, 12'h5A5, 0, 0, 1'b0);
    check("fill_wrap_lo", mem[12'h001], 12'h5A5);
    // Zero-length requests in both modes.
    run_xfer(MODE_COPY, 12'h300, 12'h400, 12'd0, 12'h000, 0, 0, 1'b0);
    run_xfer(MODE_FILL, 12'h300, 12'h400, 12'd0, 12'h777, 0, 0, 1'b0);
    // Abort sampled on the fourth edge of an eight-word copy.
    run_xfer(MODE_COPY, 12'h200, 12'h600, 12'd8, 12'h000, 4, 0, 1'b0);
    // Overlapping ascending copy replicates the first word.
    poke(12'h020, 12'h111);
    run_xfer(MODE_COPY, 12'h020, 12'h021, 12'd3, 12'h000, 0, 0, 1'b0);
    for (int i = 1; i <= 3; i++) check("overlap", mem[12'h020 + i], 12'h111);
    // Reset mid-copy, then a normal start afterwards.
    run_xfer(MODE_COPY, 12'h700, 12'h800, 12'd8, 12'h000, 0, 4, 1'b0);
    run_xfer(MODE_COPY, 12'h700, 12'h900, 12'd5, 12'h000, 0, 0, 1'b0);
    // Start with abort together: start wins.
    run_xfer(MODE_FILL, 12'h000, 12'hA00, 12'd3, 12'h0F0, 0, 0, 1'b1);
    // Abort while idle does nothing.
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(posedge clk); #1;
    check("idle_abort_busy", busy, 0);
    check("idle_abort_done", done, 0);
    check_mem("mem_directed");

    for (int t = 0; t < 30; t++) begin
      m = 1'($urandom);
      s = 12'($urandom);
      d = 12'($urandom);
      n = 12'($urandom_range(0, 40));
      ab = 0;
      if (n >= 2 && $urandom_range(0, 3) == 0)
        ab = m ? int'($urandom_range(2, n)) : int'($urandom_range(2, n + 1));
      run_xfer(m, s, d, n, 12'($urandom), ab, 0, 1'b0);
    end
    check_mem("mem_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
